// File: rtl/ddr3_rd_return_buffer_if.sv
// Read-return buffer bus: issuer reservation/cancel pulses, wrapper read-return beats,
// user-side valid/ready stream and credit/status outputs.
//   slave  : the return buffer (drives dout*, credits, rd_credit_ok, outstanding, err_*)
//   master : issuer / wrapper / consumer side (drives rd_*, app_rd_*, dout_ready)
interface ddr3_rd_return_buffer_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              rd_reserve;
  logic              rd_cancel;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [CNT_W-1:0]  credits;
  logic              rd_credit_ok;
  logic [CNT_W-1:0]  outstanding;
  logic              err_overflow;
  logic              err_unexpected;

  modport slave (
    input  rd_reserve, rd_cancel, app_rd_data, app_rd_data_valid, app_rd_data_end, dout_ready,
    output dout, dout_valid, credits, rd_credit_ok, outstanding, err_overflow, err_unexpected
  );

  modport master (
    output rd_reserve, rd_cancel, app_rd_data, app_rd_data_valid, app_rd_data_end, dout_ready,
    input  dout, dout_valid, credits, rd_credit_ok, outstanding, err_overflow, err_unexpected
  );
endinterface

// File: rtl/ddr3_rd_return_buffer.sv
// DDR3 read-return buffer. Captures every beat from the (non-backpressurable) wrapper read
// path into a DEPTH x DATA_W FIFO, presents it first-word-fall-through on a valid/ready
// stream, and tracks reserved-but-unreturned reads so the issuer only launches a read when a
// return slot is guaranteed (credits = DEPTH - occupancy - outstanding).
// Ports:
//   ui_clk, sys_rst  clock, asynchronous active-high reset
//   bus (slave)      rd_reserve/rd_cancel in, app_rd_* in, dout/dout_valid out, dout_ready in,
//                    credits/rd_credit_ok/outstanding out, sticky err_overflow/err_unexpected out
// Optional: define DDR3_RDBUF_STATS_EN to add rd_beat_count (beats written, wraps at 2^32)
//   and max_outstanding (high-water mark of outstanding).
module ddr3_rd_return_buffer #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   ui_clk,
  input  logic                   sys_rst,
  ddr3_rd_return_buffer_if.slave bus
`ifdef DDR3_RDBUF_STATS_EN
  ,
  output logic [31:0]            rd_beat_count,
  output logic [CNT_W-1:0]       max_outstanding
`endif
);

  localparam int unsigned     ADDR_W    = $clog2(DEPTH);
  localparam logic [CNT_W:0]  DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic              err_ov_q, err_ov_d;
  logic              err_un_q, err_un_d;

  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W:0]    used;
  logic [CNT_W-1:0]  credits_w;
  logic [CNT_W-1:0]  dec;
  logic              empty, full, pop, push, reserve_ok;

  // Beat-end carries no information with one beat per command.
  logic unused_end;
  assign unused_end = bus.app_rd_data_end;

  always_comb begin
    occupancy = wr_ptr_q - rd_ptr_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    used      = {1'b0, occupancy} + {1'b0, out_q};
    // Unexpected beats can push occupancy+outstanding past DEPTH; clamp rather than wrap.
    credits_w = (used >= DEPTH_EXT) ? '0 : CNT_W'(DEPTH_EXT - used);
  end

  always_comb begin
    pop        = !empty && bus.dout_ready;
    // A pop in the same cycle frees the slot the incoming beat needs.
    push       = bus.app_rd_data_valid && (!full || pop);
    reserve_ok = bus.rd_reserve && (credits_w != '0);
    dec        = CNT_W'(bus.rd_cancel) + CNT_W'(bus.app_rd_data_valid);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    err_ov_d = err_ov_q;
    err_un_d = err_un_q;
    if (bus.rd_reserve && (credits_w == '0)) err_ov_d = 1'b1;
    if (bus.app_rd_data_valid && !push)      err_ov_d = 1'b1;

    // Decrements are taken against the registered count and saturate; an accepted
    // reservation is added on top, so the net of all three lands in one cycle.
    if (dec > out_q) begin
      out_d    = '0;
      err_un_d = 1'b1;
    end else begin
      out_d = out_q - dec;
    end
    out_d = out_d + CNT_W'(reserve_ok);
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      err_ov_q <= 1'b0;
      err_un_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      err_ov_q <= err_ov_d;
      err_un_q <= err_un_d;
    end
  end

  // Storage is not reset; contents are only visible behind dout_valid.
  always_ff @(posedge ui_clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.app_rd_data;
  end

  assign bus.dout           = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign bus.dout_valid     = !empty;
  assign bus.credits        = credits_w;
  assign bus.rd_credit_ok   = (credits_w != '0);
  assign bus.outstanding    = out_q;
  assign bus.err_overflow   = err_ov_q;
  assign bus.err_unexpected = err_un_q;

`ifdef DDR3_RDBUF_STATS_EN
  logic [31:0]      beat_cnt_q;
  logic [CNT_W-1:0] max_out_q;

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      beat_cnt_q <= '0;
      max_out_q  <= '0;
    end else begin
      if (push) beat_cnt_q <= beat_cnt_q + 32'd1;
      if (out_d > max_out_q) max_out_q <= out_d;
    end
  end

  assign rd_beat_count   = beat_cnt_q;
  assign max_outstanding = max_out_q;
`endif

endmodule

// File: tb/tb_ddr3_rd_return_buffer.sv
// Bench for ddr3_rd_return_buffer: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the buffer's rules.
module tb_ddr3_rd_return_buffer;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic ui_clk  = 1'b0;
  logic sys_rst = 1'b1;

  ddr3_rd_return_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef DDR3_RDBUF_STATS_EN
  logic [31:0]      rd_beat_count;
  logic [CNT_W-1:0] max_outstanding;
`endif

  ddr3_rd_return_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .ui_clk  (ui_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
`ifdef DDR3_RDBUF_STATS_EN
    ,
    .rd_beat_count   (rd_beat_count),
    .max_outstanding (max_outstanding)
`endif
  );

  always #5 ui_clk = ~ui_clk;

  // Reference model state
  logic [DATA_W-1:0] m_fifo[$];
  int                m_out;
  bit                m_eov, m_eun;
  bit [31:0]         m_beats;
  int                m_max;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_credits();
    int c;
    c = int'(DEPTH) - m_fifo.size() - m_out;
    return (c < 0) ? 0 : c;
  endfunction

  task automatic check_outputs();
    chk("dout_valid", DATA_W'(bus.dout_valid), DATA_W'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("dout", bus.dout, m_fifo[0]);
    chk("credits", DATA_W'(bus.credits), DATA_W'(m_credits()));
    chk("rd_credit_ok", DATA_W'(bus.rd_credit_ok), DATA_W'(m_credits() != 0));
    chk("outstanding", DATA_W'(bus.outstanding), DATA_W'(m_out));
    chk("err_overflow", DATA_W'(bus.err_overflow), DATA_W'(m_eov));
    chk("err_unexpected", DATA_W'(bus.err_unexpected), DATA_W'(m_eun));
`ifdef DDR3_RDBUF_STATS_EN
    chk("rd_beat_count", DATA_W'(rd_beat_count), DATA_W'(m_beats));
    chk("max_outstanding", DATA_W'(max_outstanding), DATA_W'(m_max));
`endif
  endtask

  task automatic drive_idle();
    bus.rd_reserve        = 1'b0;
    bus.rd_cancel         = 1'b0;
    bus.app_rd_data       = '0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data_end   = 1'b0;
    bus.dout_ready        = 1'b0;
  endtask

  // Asserts reset mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    @(negedge ui_clk);
    drive_idle();
    sys_rst = 1'b1;
    m_fifo.delete();
    m_out   = 0;
    m_eov   = 1'b0;
    m_eun   = 1'b0;
    m_beats = '0;
    m_max   = 0;
    #1;
    check_outputs();
    @(negedge ui_clk);
    sys_rst = 1'b0;
    @(posedge ui_clk);
    #1;
  endtask

  // One clock of stimulus: drive at the falling edge, check registered outputs, then
  // advance the model by the rules for what the rising edge should do.
  task automatic step(input bit res, input bit can, input bit vld, input bit rdy);
    logic [DATA_W-1:0] d;
    int  cred, dec;
    bit  pop, was_full;
    @(negedge ui_clk);
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
    bus.rd_reserve        = res;
    bus.rd_cancel         = can;
    bus.app_rd_data       = d;
    bus.app_rd_data_valid = vld;
    bus.app_rd_data_end   = vld;
    bus.dout_ready        = rdy;
    #1;
    check_outputs();

    cred     = m_credits();
    was_full = (m_fifo.size() == DEPTH);
    pop      = (m_fifo.size() > 0) && rdy;
    if (res && cred == 0) m_eov = 1'b1;
    dec = int'(can) + int'(vld);
    if (dec > m_out) begin
      m_eun = 1'b1;
      m_out = 0;
    end else begin
      m_out = m_out - dec;
    end
    if (res && cred > 0) m_out++;
    if (pop) void'(m_fifo.pop_front());
    if (vld) begin
      if (!was_full || pop) begin
        m_fifo.push_back(d);
        m_beats++;
      end else begin
        m_eov = 1'b1;
      end
    end
    if (m_out > m_max) m_max = m_out;
    @(posedge ui_clk);
    #1;
  endtask

  initial begin
    drive_idle();

    // 1: reset values
    do_reset();
    chk("t1_credits", DATA_W'(bus.credits), DATA_W'(16));
    chk("t1_credit_ok", DATA_W'(bus.rd_credit_ok), DATA_W'(1));
    chk("t1_dout_valid", DATA_W'(bus.dout_valid), DATA_W'(0));
    chk("t1_err_ov", DATA_W'(bus.err_overflow), DATA_W'(0));
    chk("t1_err_un", DATA_W'(bus.err_unexpected), DATA_W'(0));

    // 2: four reads, returns two cycles later, drained in order
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    chk("t2_out4", DATA_W'(bus.outstanding), DATA_W'(4));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    chk("t2_first_beat_visible", DATA_W'(bus.dout_valid), DATA_W'(1));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t2_out0", DATA_W'(bus.outstanding), DATA_W'(0));
    chk("t2_credits", DATA_W'(bus.credits), DATA_W'(16));
    chk("t2_empty", DATA_W'(bus.dout_valid), DATA_W'(0));

    // 3: exhaust credits, then one reserve too many
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    chk("t3_credit_ok", DATA_W'(bus.rd_credit_ok), DATA_W'(0));
    step(1, 0, 0, 0);
    chk("t3_err_ov", DATA_W'(bus.err_overflow), DATA_W'(1));
    chk("t3_out16", DATA_W'(bus.outstanding), DATA_W'(16));

    // 4: reserve + cancel + beat together
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("t4_out2", DATA_W'(bus.outstanding), DATA_W'(2));
    chk("t4_credits", DATA_W'(bus.credits), DATA_W'(13));
    chk("t4_err_ov", DATA_W'(bus.err_overflow), DATA_W'(0));
    chk("t4_err_un", DATA_W'(bus.err_unexpected), DATA_W'(0));

    // 5: unexpected beat and cancel with nothing outstanding
    do_reset();
    step(0, 0, 1, 0);
    chk("t5_err_un", DATA_W'(bus.err_unexpected), DATA_W'(1));
    chk("t5_stored", DATA_W'(bus.dout_valid), DATA_W'(1));
    step(0, 1, 0, 0);
    chk("t5_out0", DATA_W'(bus.outstanding), DATA_W'(0));

    // 6: full FIFO, beat with and without a same-cycle pop
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    chk("t6_full_credits", DATA_W'(bus.credits), DATA_W'(0));
    step(0, 0, 1, 1);
    chk("t6_pop_err_ov", DATA_W'(bus.err_overflow), DATA_W'(0));
    chk("t6_still_full", DATA_W'(bus.credits), DATA_W'(0));
    step(0, 0, 1, 0);
    chk("t6_drop_err_ov", DATA_W'(bus.err_overflow), DATA_W'(1));
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1);

    // Random, well-behaved issuer: reserve only with credit, return only what is owed
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      bit res, can, vld, rdy;
      res = (m_credits() > 0) && ($urandom_range(0, 1) == 1);
      vld = (m_out > 0) && ($urandom_range(0, 2) == 0);
      can = (m_out > int'(vld)) && ($urandom_range(0, 15) == 0);
      rdy = (i < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(res, can, vld, rdy);
    end

    // Random, unconstrained inputs including protocol violations
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
